// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: handshake state
// encoding and default bundle widths for each stage boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int IF_ID_CTRL_W  = 4;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 8;
  localparam int ID_EX_DATA_W  = 101;
  localparam int EX_MEM_CTRL_W = 6;
  localparam int EX_MEM_DATA_W = 101;
  localparam int MEM_WB_CTRL_W = 3;
  localparam int MEM_WB_DATA_W = 69;

  localparam int DEF_CTRL_W = ID_EX_CTRL_W;
  localparam int DEF_DATA_W = ID_EX_DATA_W;
  localparam int DEF_CNT_W  = 16;

  // The skid buffer only refuses new bundles once both entries are occupied.
  function automatic logic has_room(input pipe_state_t s);
    return s != FULL;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones and is cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, two-entry skid
// buffer, synchronous flush, bubble (NOP) insertion and a stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              Clk,
  input  logic              Clr_n,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [CNT_W-1:0]  Stall_Count
);

  pipe_state_t       state;
  pipe_state_t       state_nxt;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              deliver;

  assign Out_Valid = (state != EMPTY);
  assign Out_Ctrl  = Out_Valid ? main_ctrl : '0;
  assign Out_Data  = main_data;

  always_comb begin
    accept    = In_Valid && In_Ready;
    deliver   = Out_Valid && Out_Ready;
    state_nxt = state;
    if (Flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) state_nxt = HALF;
        HALF: begin
          if (accept && !deliver)      state_nxt = FULL;
          else if (!accept && deliver) state_nxt = EMPTY;
        end
        FULL:    if (deliver) state_nxt = HALF;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // In_Ready is registered from the next state so downstream ready never
  // reaches upstream combinationally; the skid entry absorbs the one bundle
  // that may arrive while that decision is a cycle late.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state     <= EMPTY;
      In_Ready  <= 1'b0;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state    <= state_nxt;
      In_Ready <= has_room(state_nxt);
      if (!Flush) begin
        case (state)
          EMPTY: begin
            if (accept) begin
              main_ctrl <= In_Ctrl;
              main_data <= In_Data;
            end
          end
          HALF: begin
            if (accept && deliver) begin
              main_ctrl <= In_Ctrl;
              main_data <= In_Data;
            end else if (accept) begin
              skid_ctrl <= In_Ctrl;
              skid_data <= In_Data;
            end
          end
          FULL: begin
            if (deliver) begin
              main_ctrl <= skid_ctrl;
              main_data <= skid_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .Clk  (Clk),
    .Clr_n(Clr_n),
    .inc  (Out_Valid && !Out_Ready),
    .count(Stall_Count)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks of pipe_stage_reg against hand-computed
// values and a queue reference model.
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 101;

  logic          Clk = 1'b0;
  logic          Clr_n;
  logic          Flush;
  logic          In_Valid;
  logic          In_Ready;
  logic [CW-1:0] In_Ctrl;
  logic [DW-1:0] In_Data;
  logic          Out_Valid;
  logic          Out_Ready;
  logic [CW-1:0] Out_Ctrl;
  logic [DW-1:0] Out_Data;
  logic [15:0]   Stall_Count;

  logic          s_in_ready;
  logic          s_out_valid;
  logic [CW-1:0] s_out_ctrl;
  logic [DW-1:0] s_out_data;
  logic [3:0]    s_stall;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) dut (
    .Clk(Clk), .Clr_n(Clr_n), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Ctrl(Out_Ctrl), .Out_Data(Out_Data),
    .Stall_Count(Stall_Count)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(4)) dut4 (
    .Clk(Clk), .Clr_n(Clr_n), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(s_in_ready), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
    .Out_Valid(s_out_valid), .Out_Ready(Out_Ready), .Out_Ctrl(s_out_ctrl), .Out_Data(s_out_data),
    .Stall_Count(s_stall)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mkdata(input logic [7:0] c);
    return {c, 85'h0, c, c};
  endfunction

  task automatic test_reset();
    Clr_n = 1'b0; Flush = 1'b0; Out_Ready = 1'b1;
    In_Valid = 1'b1; In_Ctrl = 8'hAA; In_Data = mkdata(8'hAA);
    step(); step(); step();
    checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", Out_Valid); end
    checks++; if (Out_Ctrl !== 8'h00) begin failures++; $display("FAIL reset_out_ctrl got=%h exp=00", Out_Ctrl); end
    checks++; if (Out_Data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", Out_Data); end
    checks++; if (In_Ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", In_Ready); end
    checks++; if (Stall_Count !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", Stall_Count); end
    In_Valid = 1'b0;
    Clr_n = 1'b1;
    step();
    checks++; if (In_Ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", In_Ready); end
    checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%b exp=0", Out_Valid); end
  endtask

  task automatic test_streaming();
    Out_Ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      In_Valid = 1'b1; In_Ctrl = 8'(i); In_Data = mkdata(8'(i * 17));
      step();
      checks++; if (Out_Valid !== 1'b1 || Out_Ctrl !== 8'(i)) begin
        failures++; $display("FAIL stream_ctrl[%0d] got=%b/%h exp=1/%h", i, Out_Valid, Out_Ctrl, 8'(i));
      end
      checks++; if (Out_Data !== mkdata(8'(i * 17))) begin
        failures++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, Out_Data, mkdata(8'(i * 17)));
      end
      checks++; if (In_Ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, In_Ready); end
    end
    In_Valid = 1'b0;
    step();
    checks++; if (Out_Valid !== 1'b0 || Out_Ctrl !== 8'h00) begin
      failures++; $display("FAIL stream_drain got=%b/%h exp=0/00", Out_Valid, Out_Ctrl);
    end
  endtask

  task automatic test_backpressure();
    Out_Ready = 1'b0;
    In_Valid = 1'b1; In_Ctrl = 8'h21; In_Data = mkdata(8'h21);
    step();
    In_Ctrl = 8'h22; In_Data = mkdata(8'h22);
    step();
    In_Valid = 1'b0;
    checks++; if (In_Ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", In_Ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (Out_Ctrl !== 8'h21 || Out_Data !== mkdata(8'h21)) begin
        failures++; $display("FAIL bp_hold[%0d] got=%h exp=21", i, Out_Ctrl);
      end
    end
    checks++; if (Stall_Count !== 16'd5) begin failures++; $display("FAIL bp_stall_count got=%0d exp=5", Stall_Count); end
    Out_Ready = 1'b1;
    #1;
    checks++; if (In_Ready !== 1'b0) begin failures++; $display("FAIL bp_ready_comb got=%b exp=0", In_Ready); end
    step();
    checks++; if (Out_Valid !== 1'b1 || Out_Ctrl !== 8'h22 || Out_Data !== mkdata(8'h22)) begin
      failures++; $display("FAIL bp_second got=%b/%h exp=1/22", Out_Valid, Out_Ctrl);
    end
    checks++; if (In_Ready !== 1'b1) begin failures++; $display("FAIL bp_ready_reopen got=%b exp=1", In_Ready); end
    step();
    checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", Out_Valid); end
    checks++; if (Stall_Count !== 16'd5) begin failures++; $display("FAIL bp_stall_after got=%0d exp=5", Stall_Count); end
  endtask

  task automatic test_flush();
    Out_Ready = 1'b0;
    In_Valid = 1'b1; In_Ctrl = 8'h31; In_Data = mkdata(8'h31);
    step();
    In_Ctrl = 8'h32; In_Data = mkdata(8'h32);
    step();
    Flush = 1'b1; In_Ctrl = 8'h33; In_Data = mkdata(8'h33);
    step();
    checks++; if (Out_Valid !== 1'b0 || Out_Ctrl !== 8'h00) begin
      failures++; $display("FAIL flush_full got=%b/%h exp=0/00", Out_Valid, Out_Ctrl);
    end
    checks++; if (In_Ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", In_Ready); end
    checks++; if (Stall_Count !== 16'd7) begin failures++; $display("FAIL flush_stall_kept got=%0d exp=7", Stall_Count); end
    In_Ctrl = 8'h34;
    step();
    checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL flush_accept_drop got=%b exp=0", Out_Valid); end
    Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
    step();
    checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost got=%b exp=0", Out_Valid); end
  endtask

  task automatic test_saturation();
    Out_Ready = 1'b0;
    In_Valid = 1'b1; In_Ctrl = 8'h41; In_Data = mkdata(8'h41);
    step();
    In_Valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 7) begin
        checks++; if (s_stall !== 4'd14) begin failures++; $display("FAIL sat_pre got=%0d exp=14", s_stall); end
      end
    end
    checks++; if (s_stall !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", s_stall); end
    checks++; if (Stall_Count !== 16'd27) begin failures++; $display("FAIL sat_wide got=%0d exp=27", Stall_Count); end
    checks++; if (Out_Ctrl !== 8'h41) begin failures++; $display("FAIL sat_hold_ctrl got=%h exp=41", Out_Ctrl); end
    Out_Ready = 1'b1;
    step();
    checks++; if (Out_Valid !== 1'b0 || s_out_valid !== 1'b0) begin
      failures++; $display("FAIL sat_drain got=%b/%b exp=0/0", Out_Valid, s_out_valid);
    end
  endtask

  task automatic test_async_reset();
    Out_Ready = 1'b0;
    In_Valid = 1'b1; In_Ctrl = 8'h51; In_Data = mkdata(8'h51);
    step();
    In_Valid = 1'b0;
    #2 Clr_n = 1'b0;
    #1;
    checks++; if (Out_Valid !== 1'b0 || Out_Data !== '0 || Out_Ctrl !== 8'h00) begin
      failures++; $display("FAIL async_reset_out got=%b/%h exp=0/0", Out_Valid, Out_Ctrl);
    end
    checks++; if (In_Ready !== 1'b0 || Stall_Count !== 16'd0 || s_stall !== 4'd0) begin
      failures++; $display("FAIL async_reset_ctl got=%b/%0d/%0d exp=0/0/0", In_Ready, Stall_Count, s_stall);
    end
    step();
    Clr_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic [CW-1:0] q_ctrl[$];
    logic [DW-1:0] q_data[$];
    logic [CW-1:0] exp_ctrl;
    logic [DW-1:0] exp_data;
    int bad = 0;
    bit acc, del;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      exp_ctrl = (q_ctrl.size() > 0) ? q_ctrl[0] : '0;
      checks++;
      if (Out_Valid !== (q_ctrl.size() > 0) || Out_Ctrl !== exp_ctrl ||
          In_Ready !== (q_ctrl.size() < 2)) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL rand_ctl[%0d] got=%b/%h/%b exp=%b/%h/%b", cyc, Out_Valid, Out_Ctrl,
                               In_Ready, q_ctrl.size() > 0, exp_ctrl, q_ctrl.size() < 2);
      end
      if (q_data.size() > 0) begin
        exp_data = q_data[0];
        checks++;
        if (Out_Data !== exp_data) begin
          failures++; bad++;
          if (bad < 10) $display("FAIL rand_data[%0d] got=%h exp=%h", cyc, Out_Data, exp_data);
        end
      end
      In_Valid  = ($urandom_range(0, 3) != 0);
      Out_Ready = ($urandom_range(0, 2) != 0);
      Flush     = ($urandom_range(0, 49) == 0);
      In_Ctrl   = 8'($urandom);
      In_Data   = {5'($urandom), $urandom, $urandom, $urandom};
      if (Flush) begin
        q_ctrl.delete(); q_data.delete();
      end else begin
        del = (q_ctrl.size() > 0) && Out_Ready;
        acc = In_Valid && (q_ctrl.size() < 2);
        if (del) begin void'(q_ctrl.pop_front()); void'(q_data.pop_front()); end
        if (acc) begin q_ctrl.push_back(In_Ctrl); q_data.push_back(In_Data); end
      end
      step();
    end
    Flush = 1'b0; In_Valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
